// File: rtl/activity_led_array_if.sv
// Bundle of per-channel activity strobes, mode selects, global brightness
// and LED drives for activity_led_array.
interface activity_led_array_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned PWM_W  = 8
);
    logic [NUM_CH-1:0]   activity;
    logic [2*NUM_CH-1:0] mode;
    logic [PWM_W-1:0]    brightness;
    logic [NUM_CH-1:0]   led;

    // Peripheral side: drives strobes and configuration, observes LEDs.
    modport master (
        output activity,
        output mode,
        output brightness,
        input  led
    );

    // LED array side.
    modport slave (
        input  activity,
        input  mode,
        input  brightness,
        output led
    );
endinterface

// File: rtl/activity_led_array.sv
// Multi-channel activity LED stretcher.
// Each channel stretches activity pulses for HOLD_CYCLES cycles and shows
// them as off / hold / blink / forced-on depending on its 2-bit mode.
// Optional global PWM dimming is compiled in with `define ACTIVITY_LED_PWM_EN.
module activity_led_array #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned HOLD_CYCLES = 8000000,
    parameter int unsigned BLINK_HALF  = 2000000,
    parameter int unsigned PWM_W       = 8
) (
    input logic                 clk,
    input logic                 reset,
    activity_led_array_if.slave io
);

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0]  hold_q  [NUM_CH];
    logic [CNT_W-1:0]  hold_d  [NUM_CH];
    logic [CNT_W-1:0]  blink_q [NUM_CH];
    logic [CNT_W-1:0]  blink_d [NUM_CH];
    logic [NUM_CH-1:0] phase_q;
    logic [NUM_CH-1:0] phase_d;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] raw;

    // Per-channel hold/blink next state and raw indication from registers and mode.
    always_comb begin
        hold_d  = hold_q;
        blink_d = blink_q;
        phase_d = phase_q;
        active  = '0;
        raw     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            active[i] = (hold_q[i] != '0);

            if (io.activity[i]) begin
                hold_d[i] = HOLD_LOAD;
            end else if (active[i]) begin
                hold_d[i] = hold_q[i] - CNT_W'(1);
            end

            // A fresh episode always starts in the visible half of the blink.
            if (io.activity[i] && !active[i]) begin
                blink_d[i] = '0;
                phase_d[i] = 1'b1;
            end else if (active[i]) begin
                if (blink_q[i] == BLINK_LAST) begin
                    blink_d[i] = '0;
                    phase_d[i] = ~phase_q[i];
                end else begin
                    blink_d[i] = blink_q[i] + CNT_W'(1);
                end
            end

            unique case (io.mode[2*i +: 2])
                2'b00:   raw[i] = 1'b0;
                2'b01:   raw[i] = active[i];
                2'b10:   raw[i] = active[i] & phase_q[i];
                default: raw[i] = 1'b1;
            endcase
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q  <= '{default: '0};
            blink_q <= '{default: '0};
            phase_q <= '0;
        end else begin
            hold_q  <= hold_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
        end
    end

`ifdef ACTIVITY_LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q;
    logic [PWM_W-1:0] pwm_cnt_d;
    logic             pwm_on;

    // Free-running PWM counter and shared duty gate.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        pwm_on    = (io.brightness == '1) || (pwm_cnt_q < io.brightness);
        io.led    = raw & {NUM_CH{pwm_on}};
    end

    // PWM counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`else
    logic unused_brightness;

    // Without dimming the raw indication drives the pins directly.
    always_comb begin
        unused_brightness = ^io.brightness;
        io.led            = raw;
    end
`endif

endmodule
